// File: rtl/cla_pkg.sv
// Shared types and the single-group carry-lookahead helper for cla_pipe and cla_seg.
package cla_pkg;

    localparam int unsigned CLA_BLOCK_DEF = 4;
    localparam int unsigned CLA_BLOCK_MAX = 16;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Flattened sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]cin.
    // Bits above the real group width must be passed in as zero.
    function automatic logic [CLA_BLOCK_MAX:0] cla_carries(input logic [CLA_BLOCK_MAX-1:0] p,
                                                           input logic [CLA_BLOCK_MAX-1:0] g,
                                                           input logic                     cin);
        logic [CLA_BLOCK_MAX:0] c;
        logic                   term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CLA_BLOCK_MAX; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_pipe_if.sv
// Operand/result bundle of cla_pipe. Sat exists only when CLA_PIPE_SAT_EN is defined.
interface cla_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             En;
    logic             In_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
`ifdef CLA_PIPE_SAT_EN
    logic             Sat;
`endif
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             Out_valid;

`ifdef CLA_PIPE_SAT_EN
    modport master (output En, In_valid, A, B, Cin, Sub, Sat, input S, Cout, Ovf, Out_valid);
    modport slave  (input En, In_valid, A, B, Cin, Sub, Sat, output S, Cout, Ovf, Out_valid);
`else
    modport master (output En, In_valid, A, B, Cin, Sub, input S, Cout, Ovf, Out_valid);
    modport slave  (input En, In_valid, A, B, Cin, Sub, output S, Cout, Ovf, Out_valid);
`endif

endinterface

// File: rtl/cla_seg.sv
// Combinational SEG-bit adder: BLOCK-wide lookahead groups, group carries rippled between groups.
module cla_seg
    import cla_pkg::*;
#(
    parameter int unsigned SEG   = 4,
    parameter int unsigned BLOCK = CLA_BLOCK_DEF
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);
    localparam int unsigned NGRP = SEG / BLOCK;

    pg_t [SEG-1:0] pg;
    logic [NGRP:0] gc;

    always_comb begin
        for (int i = 0; i < SEG; i++) begin
            pg[i].p = a[i] ^ b[i];
            pg[i].g = a[i] & b[i];
        end
    end

    assign gc[0] = cin;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        logic [CLA_BLOCK_MAX-1:0] pz;
        logic [CLA_BLOCK_MAX-1:0] gz;
        logic [CLA_BLOCK_MAX:0]   c;

        always_comb begin
            pz = '0;
            gz = '0;
            for (int i = 0; i < BLOCK; i++) begin
                pz[i] = pg[gi*BLOCK+i].p;
                gz[i] = pg[gi*BLOCK+i].g;
            end
            c = cla_carries(pz, gz, gc[gi]);
        end

        assign s[gi*BLOCK +: BLOCK] = pz[BLOCK-1:0] ^ c[BLOCK-1:0];
        assign gc[gi+1]             = c[BLOCK];
    end

    assign cout = gc[NGRP];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead add/sub split into STAGES segments, with valid and global stall.
// Optional output saturation is compiled in with CLA_PIPE_SAT_EN.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 1,
    parameter int unsigned BLOCK  = CLA_BLOCK_DEF
) (
    input logic      Clk,
    input logic      Rst,
    cla_pipe_if.slave bus
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if ((WIDTH % STAGES) != 0 || (SEG % BLOCK) != 0 || BLOCK > CLA_BLOCK_MAX) begin : g_bad_cfg
        $error("cla_pipe: WIDTH must split into STAGES segments of whole BLOCK groups");
    end

    // Stage k registers hold full-width operands (B already inverted for subtract),
    // the result bits produced so far and the carry into segment k+1.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [SEG-1:0]   seg_s [STAGES];
    logic             seg_c [STAGES];
`ifdef CLA_PIPE_SAT_EN
    logic             sat_q   [STAGES];
    logic             sat_src [STAGES];
`endif

    always_comb begin
        a_src[0] = bus.A;
        b_src[0] = bus.Sub ? ~bus.B : bus.B;
        s_src[0] = '0;
        c_src[0] = bus.Sub | bus.Cin;
        v_src[0] = bus.In_valid;
`ifdef CLA_PIPE_SAT_EN
        sat_src[0] = bus.Sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
`ifdef CLA_PIPE_SAT_EN
            sat_src[k] = sat_q[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
            s_d[k]                 = s_src[k];
            s_d[k][k*SEG +: SEG]   = seg_s[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        cla_seg #(
            .SEG   (SEG),
            .BLOCK (BLOCK)
        ) u_seg (
            .a    (a_src[k][k*SEG +: SEG]),
            .b    (b_src[k][k*SEG +: SEG]),
            .cin  (c_src[k]),
            .s    (seg_s[k]),
            .cout (seg_c[k])
        );
    end

    // Bubbles advance only the valid bit; data of an invalid slot holds.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else if (bus.En) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src[k];
                if (v_src[k]) begin
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= seg_c[k];
`ifdef CLA_PIPE_SAT_EN
                    sat_q[k] <= sat_src[k];
`endif
                end
            end
        end
    end

    logic a_msb;
    logic b_msb;
    logic ovf;

    always_comb begin
        a_msb = a_q[LAST][WIDTH-1];
        b_msb = b_q[LAST][WIDTH-1];
        ovf   = (a_msb == b_msb) && (s_q[LAST][WIDTH-1] != a_msb);
        bus.S = s_q[LAST];
`ifdef CLA_PIPE_SAT_EN
        if (sat_q[LAST] && ovf) begin
            bus.S = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        bus.Cout      = c_q[LAST];
        bus.Ovf       = ovf;
        bus.Out_valid = v_q[LAST];
    end

endmodule

// File: tb/tb_cla_pipe.sv
// Randomised self-checking bench for cla_pipe (WIDTH=16, STAGES=4) against a signed-arithmetic model.
module tb_cla_pipe;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } res_t;
    typedef struct {
        int   due;
        res_t r;
    } pend_t;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } dir_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    cla_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .BLOCK  (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    en_cnt = 0;
    pend_t pend_q[$];
    res_t  m;
    logic  m_valid = 1'b0;
    logic  drv_sat = 1'b0;

    // Reference: true signed/unsigned sums, overflow = signed result out of 16-bit range.
    function automatic res_t ref_calc(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic sub, input logic sat);
        res_t r;
        int   su;
        int   ss;
        if (sub) begin
            su = int'(a) - int'(b) + 65536;
            ss = int'($signed(a)) - int'($signed(b));
        end else begin
            su = int'(a) + int'(b) + int'(cin);
            ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        r.s    = su[15:0];
        r.cout = su[16];
        r.ovf  = (ss > 32767) || (ss < -32768);
        if (sat && r.ovf) r.s = (ss > 0) ? 16'h7FFF : 16'h8000;
        return r;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m.s     = '0;
        m.cout  = 1'b0;
        m.ovf   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic drive(input logic en, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic sat);
        bus.En       = en;
        bus.In_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.Sub      = sub;
        drv_sat      = sat;
`ifdef CLA_PIPE_SAT_EN
        bus.Sat      = sat;
`endif
    endtask

    // One clock edge; the model counts enabled edges and retires a result STAGES of them later.
    task automatic step();
        logic en_s = bus.En;
        logic v_s  = bus.In_valid;
        res_t e    = ref_calc(bus.A, bus.B, bus.Cin, bus.Sub, drv_sat & SAT_BUILD);
        @(posedge Clk);
        if (en_s) begin
            en_cnt++;
            if (v_s) pend_q.push_back('{due: en_cnt + int'(STAGES) - 1, r: e});
            if (pend_q.size() != 0 && pend_q[0].due == en_cnt) begin
                m       = pend_q.pop_front().r;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        #7 Rst = 1'b1;
        repeat (STAGES + 1) step();
        #2 Rst = 1'b0;
        #1;
        checks++;
        if (bus.S !== 16'h0000) begin
            errors++;
            $display("FAIL reset_s got=%h exp=0000", bus.S);
        end
        checks++;
        if (bus.Cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cout got=%b exp=0", bus.Cout);
        end
        checks++;
        if (bus.Ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b exp=0", bus.Ovf);
        end
        checks++;
        if (bus.Out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", bus.Out_valid);
        end
        model_reset();
        @(posedge Clk);
        #3 Rst = 1'b1;
        drive(1'b1, 1'b1, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 1; i < int'(STAGES); i++) begin
            checks++;
            if (bus.Out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_early_valid edge=%0d got=%b exp=0", i, bus.Out_valid);
            end
            drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++;
        if ({bus.Out_valid, bus.S} !== {1'b1, 16'd7}) begin
            errors++;
            $display("FAIL post_reset_3p4 got v=%b s=%h exp v=1 s=0007", bus.Out_valid, bus.S);
        end
    endtask

    task automatic test_directed();
        dir_t tbl[$];
        tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        tbl.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0});
        tbl.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});
        tbl.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1});
        tbl.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0});
`ifdef CLA_PIPE_SAT_EN
        tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1});
        tbl.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1});
`else
        tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1});
`endif
        foreach (tbl[i]) begin
            drive(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat);
            step();
            drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            repeat (STAGES - 1) step();
            checks++;
            if ({bus.Out_valid, bus.Cout, bus.Ovf, bus.S} !==
                {1'b1, tbl[i].cout, tbl[i].ovf, tbl[i].s}) begin
                errors++;
                $display("FAIL directed_%0d got v=%b c=%b o=%b s=%h exp v=1 c=%b o=%b s=%h", i,
                         bus.Out_valid, bus.Cout, bus.Ovf, bus.S, tbl[i].cout, tbl[i].ovf,
                         tbl[i].s);
            end
        end
    endtask

    task automatic test_stall_bubble();
        logic [15:0] got[$];
        logic        rows_en[$] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        rows_v[$]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] rows_a[$]  = '{16'd1, 16'd2, 16'd0, 16'd9, 16'd9, 16'd3};
        for (int i = 0; i < int'(STAGES) + 8; i++) begin
            logic en = (i < 6) ? rows_en[i] : 1'b1;
            if (i < 6) drive(en, rows_v[i], rows_a[i], rows_a[i], 1'b0, 1'b0, 1'b0);
            else drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            step();
            checks++;
            if ({bus.Out_valid, bus.Cout, bus.Ovf, bus.S} !== {m_valid, m.cout, m.ovf, m.s}) begin
                errors++;
                $display("FAIL stall_cycle_%0d got v=%b c=%b o=%b s=%h exp v=%b c=%b o=%b s=%h",
                         i, bus.Out_valid, bus.Cout, bus.Ovf, bus.S, m_valid, m.cout, m.ovf, m.s);
            end
            if (en && bus.Out_valid) got.push_back(bus.S);
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL stall_result_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 16'(2 * (i + 1))) begin
                    errors++;
                    $display("FAIL stall_order_%0d got=%h exp=%h", i, got[i], 16'(2 * (i + 1)));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400 + int'(STAGES) + 4; i++) begin
            if (i < 400) begin
                drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 16'($urandom),
                      16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            end
            step();
            checks++;
            if ({bus.Out_valid, bus.Cout, bus.Ovf, bus.S} !== {m_valid, m.cout, m.ovf, m.s}) begin
                errors++;
                $display("FAIL random_cycle_%0d got v=%b c=%b o=%b s=%h exp v=%b c=%b o=%b s=%h",
                         i, bus.Out_valid, bus.Cout, bus.Ovf, bus.S, m_valid, m.cout, m.ovf, m.s);
            end
        end
        checks++;
        if (pend_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain pending=%0d exp=0", pend_q.size());
        end
    endtask

    task automatic test_sweep();
        logic [16:0] sum_q[$];
        int          n = 0;
        for (int i = 0; i < 512 + int'(STAGES) + 2; i++) begin
            if (i < 512) begin
                logic [15:0] a   = 16'((i >> 5) & 15) << 12;
                logic [15:0] b   = 16'((i >> 1) & 15) << 12;
                logic        cin = 1'(i & 1);
                drive(1'b1, 1'b1, a, b, cin, 1'b0, 1'b0);
                sum_q.push_back(17'(a) + 17'(b) + 17'(cin));
            end else begin
                drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            end
            step();
            checks++;
            if (bus.Out_valid !== m_valid) begin
                errors++;
                $display("FAIL sweep_valid_%0d got=%b exp=%b", i, bus.Out_valid, m_valid);
            end
            if (bus.Out_valid === 1'b1 && sum_q.size() != 0) begin
                logic [16:0] exp_sum = sum_q.pop_front();
                n++;
                checks++;
                if ({bus.Cout, bus.S} !== exp_sum) begin
                    errors++;
                    $display("FAIL sweep_sum_%0d got=%h exp=%h", n, {bus.Cout, bus.S}, exp_sum);
                end
            end
        end
        checks++;
        if (n != 512) begin
            errors++;
            $display("FAIL sweep_count got=%0d exp=512", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_stall_bubble();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
